// File: rtl/apb_cmd_master.sv
// APB3 requester: turns a valid/ready command stream into single APB transfers with a valid/ready response.
// Optional ACCESS-phase timeout abort enabled by defining APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state, state_nxt;
  logic   cmd_acc;
  logic   timeout_hit;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  assign cmd_ready = (state == IDLE) && !PRESET;
  assign cmd_acc   = cmd_valid && cmd_ready;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge PCLK) begin
    if (PRESET)
      wait_cnt <= '0;
    else if (cmd_acc)
      wait_cnt <= '0;
    else if (state == ACCESS && !PREADY && wait_cnt != CNT_W'(TIMEOUT_CYCLES))
      wait_cnt <= wait_cnt + 1'b1;
  end

  // The edge whose wait increment would reach the limit is the aborting edge.
  assign timeout_hit = (state == ACCESS) && !PREADY && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET)
      rsp_timeout <= 1'b0;
    else if (state == ACCESS && PREADY)
      rsp_timeout <= 1'b0;
    else if (timeout_hit)
      rsp_timeout <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_acc) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered APB and response outputs; PADDR/PWRITE/PWDATA only change at accept.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_acc) begin
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PWRITE  <= cmd_write;
            PADDR   <= {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
            PWDATA  <= cmd_wdata;
          end
        end
        SETUP: PENABLE <= 1'b1;
        ACCESS: begin
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= PSLVERR;
          end else if (timeout_hit) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
